obstacle_line_scheduler: RTL and testbench

- Per-scanline scheduler that feeds the obstacle display datapath (wall-style selector and colour lookup).
- During horizontal blanking it walks the obstacle table and keeps the first SLOT_NUM entries that intersect the next line.
- During active video it drives the datapath inputs for each pixel: obstacle_on, ROM-relative x/y and absolute position fields.

---
 rtl/obstacle_line_scheduler_pkg.sv | 53 +++++
 rtl/obstacle_line_scheduler_slot_match.sv | 46 ++++
 rtl/obstacle_line_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_obstacle_line_scheduler.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_line_scheduler_pkg.sv
// Shared constants, table-entry layout, FSM encoding and slot record for the
// obstacle line scheduler.
package obstacle_line_scheduler_pkg;

    localparam int OBSTACLE_NUM    = 16;
    localparam int SLOT_NUM        = 4;
    localparam int SCREEN_WIDTH    = 10;
    localparam int PHY_WIDTH       = 14;
    localparam int OBSTACLE_WIDTH  = 10;
    localparam int BLOCK_LEN_WIDTH = 4;

    localparam int OBSTACLE_HEIGHT = 2 * OBSTACLE_WIDTH;
    localparam int IDX_WIDTH       = $clog2(OBSTACLE_NUM);
    localparam int SLOT_IDX_WIDTH  = $clog2(SLOT_NUM);
    localparam int SLOT_CNT_WIDTH  = $clog2(SLOT_NUM + 1);

    // Table entry packing, LSB first: abs_x, abs_y, scr_x, scr_y, len, valid.
    localparam int ENTRY_WIDTH = 1 + BLOCK_LEN_WIDTH + 2 * SCREEN_WIDTH + 2 * PHY_WIDTH;
    localparam int ABS_X_LSB   = 0;
    localparam int ABS_Y_LSB   = ABS_X_LSB + PHY_WIDTH;
    localparam int SCR_X_LSB   = ABS_Y_LSB + PHY_WIDTH;
    localparam int SCR_Y_LSB   = SCR_X_LSB + SCREEN_WIDTH;
    localparam int LEN_LSB     = SCR_Y_LSB + SCREEN_WIDTH;
    localparam int VALID_BIT   = LEN_LSB + BLOCK_LEN_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

    typedef struct packed {
        logic                       valid;
        logic [BLOCK_LEN_WIDTH-1:0] len;
        logic [SCREEN_WIDTH-1:0]    scr_x;
        logic [SCREEN_WIDTH-1:0]    scr_y;
        logic [PHY_WIDTH-1:0]       abs_x;
        logic [PHY_WIDTH-1:0]       abs_y;
    } slot_t;

    function automatic slot_t unpack_entry(input logic [ENTRY_WIDTH-1:0] e);
        slot_t s;
        s.valid = e[VALID_BIT];
        s.len   = e[LEN_LSB   +: BLOCK_LEN_WIDTH];
        s.scr_y = e[SCR_Y_LSB +: SCREEN_WIDTH];
        s.scr_x = e[SCR_X_LSB +: SCREEN_WIDTH];
        s.abs_y = e[ABS_Y_LSB +: PHY_WIDTH];
        s.abs_x = e[ABS_X_LSB +: PHY_WIDTH];
        return s;
    endfunction

endpackage

// File: rtl/obstacle_line_scheduler_slot_match.sv
// Per-slot horizontal range compare with lowest-index priority; purely
// combinational, registered by the caller.
module obstacle_slot_match
    import obstacle_line_scheduler_pkg::*;
(
    input  logic [SCREEN_WIDTH-1:0]                     pixel_x,
    input  logic [SLOT_NUM-1:0]                         slot_valid,
    input  logic [SLOT_NUM-1:0][BLOCK_LEN_WIDTH-1:0]    slot_len,
    input  logic [SLOT_NUM-1:0][SCREEN_WIDTH-1:0]       slot_scr_x,
    output logic                                        hit,
    output logic [SLOT_IDX_WIDTH-1:0]                   slot_idx,
    output logic [SCREEN_WIDTH-1:0]                     x_off
);

    logic [SLOT_NUM-1:0]   in_range;
    logic [SCREEN_WIDTH:0] left_ext;
    logic [SCREEN_WIDTH:0] right_ext;
    logic [SCREEN_WIDTH:0] px_ext;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        in_range  = '0;
        left_ext  = '0;
        right_ext = '0;
        hit       = 1'b0;
        slot_idx  = '0;
        x_off     = '0;
        px_ext    = {1'b0, pixel_x};

        // One extra bit keeps right edges past the screen from wrapping to small values.
        for (int s = 0; s < SLOT_NUM; s++) begin
            left_ext    = {1'b0, slot_scr_x[s]};
            right_ext   = left_ext + (SCREEN_WIDTH+1)'(slot_len[s]) * (SCREEN_WIDTH+1)'(OBSTACLE_WIDTH);
            in_range[s] = slot_valid[s] && (px_ext >= left_ext) && (px_ext < right_ext);
        end

        for (int s = SLOT_NUM - 1; s >= 0; s--) begin
            if (in_range[s]) begin
                hit      = 1'b1;
                slot_idx = SLOT_IDX_WIDTH'(s);
                x_off    = pixel_x - slot_scr_x[s];
            end
        end
    end

endmodule

// File: rtl/obstacle_line_scheduler.sv
// Scans the obstacle table during hblank into a shadow slot list, commits it
// atomically, and drives per-pixel obstacle fields from the committed list.
module obstacle_line_scheduler
    import obstacle_line_scheduler_pkg::*;
(
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    frame_start,
    input  logic                    line_start,
    input  logic [SCREEN_WIDTH-1:0] next_line_y,
    input  logic                    pixel_valid,
    input  logic [SCREEN_WIDTH-1:0] pixel_x,
    output logic                    tbl_rd_en,
    output logic [IDX_WIDTH-1:0]    tbl_addr,
    input  logic [ENTRY_WIDTH-1:0]  tbl_rd_data,
    output logic                    obstacle_on,
    output logic [SCREEN_WIDTH-1:0] obstacle_x_rom,
    output logic [SCREEN_WIDTH-1:0] obstacle_y_rom,
    output logic [PHY_WIDTH-1:0]    obstacle_abs_pos_x,
    output logic [PHY_WIDTH-1:0]    obstacle_abs_pos_y,
    output logic [PHY_WIDTH-1:0]    obstacle_block_abs_y,
    output logic                    scan_busy,
    output logic                    overflow,
    output logic                    late
);

    state_e                      state_q, state_d;
    logic [IDX_WIDTH-1:0]        idx_q, idx_d;
    logic [SCREEN_WIDTH-1:0]     line_q, line_d;
    slot_t [SLOT_NUM-1:0]        shadow_q, shadow_d;
    logic [SLOT_CNT_WIDTH-1:0]   shadow_cnt_q, shadow_cnt_d;
    slot_t [SLOT_NUM-1:0]        active_q, active_d;
    logic [SCREEN_WIDTH-1:0]     active_line_q, active_line_d;
    logic                        rd_pending_q, rd_pending_d;
    logic                        overflow_q, overflow_d;
    logic                        late_q, late_d;

    logic                        on_q, on_d;
    logic [SCREEN_WIDTH-1:0]     x_rom_q, x_rom_d;
    logic [SCREEN_WIDTH-1:0]     y_rom_q, y_rom_d;
    logic [PHY_WIDTH-1:0]        abs_x_q, abs_x_d;
    logic [PHY_WIDTH-1:0]        abs_y_q, abs_y_d;
    logic [PHY_WIDTH-1:0]        block_abs_y_q, block_abs_y_d;

    slot_t                       entry;
    logic                        entry_hit;
    logic [SCREEN_WIDTH:0]       y_top, y_bot, line_ext;
    logic                        abort, start_scan, overflow_set, late_set;

    logic [SLOT_NUM-1:0]                       slot_valid;
    logic [SLOT_NUM-1:0][BLOCK_LEN_WIDTH-1:0]  slot_len;
    logic [SLOT_NUM-1:0][SCREEN_WIDTH-1:0]     slot_scr_x;
    logic                                      match_hit;
    logic [SLOT_IDX_WIDTH-1:0]                 match_idx;
    logic [SCREEN_WIDTH-1:0]                   match_x_off;

    assign scan_busy = (state_q != ST_IDLE);
    assign abort     = line_start && (state_q == ST_SCAN || state_q == ST_DRAIN);

    // Vertical hit test on the entry returned for the previous cycle's read.
    always_comb begin
        entry     = unpack_entry(tbl_rd_data);
        y_top     = {1'b0, entry.scr_y};
        y_bot     = y_top + (SCREEN_WIDTH+1)'(OBSTACLE_HEIGHT);
        line_ext  = {1'b0, line_q};
        entry_hit = entry.valid && (entry.len != '0) && (line_ext >= y_top) && (line_ext < y_bot);
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        line_d        = line_q;
        shadow_d      = shadow_q;
        shadow_cnt_d  = shadow_cnt_q;
        active_d      = active_q;
        active_line_d = active_line_q;
        rd_pending_d  = 1'b0;
        tbl_rd_en     = 1'b0;
        tbl_addr      = '0;
        start_scan    = 1'b0;
        overflow_set  = 1'b0;

        if (rd_pending_q && !abort && entry_hit) begin
            if (shadow_cnt_q < SLOT_CNT_WIDTH'(SLOT_NUM)) begin
                for (int s = 0; s < SLOT_NUM; s++) begin
                    if (SLOT_CNT_WIDTH'(s) == shadow_cnt_q) shadow_d[s] = entry;
                end
                shadow_cnt_d = shadow_cnt_q + 1'b1;
            end else begin
                overflow_set = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                start_scan = line_start;
            end
            ST_SCAN: begin
                tbl_rd_en    = 1'b1;
                tbl_addr     = idx_q;
                rd_pending_d = 1'b1;
                idx_d        = idx_q + 1'b1;
                if (idx_q == '1) state_d = ST_DRAIN;
                start_scan   = line_start;
            end
            ST_DRAIN: begin
                state_d    = ST_COMMIT;
                start_scan = line_start;
            end
            ST_COMMIT: begin
                active_d      = shadow_q;
                active_line_d = line_q;
                state_d       = ST_IDLE;
                start_scan    = line_start;
            end
            default: state_d = ST_IDLE;
        endcase

        // A restart discards the read in flight along with the partial shadow list.
        if (start_scan) begin
            state_d      = ST_SCAN;
            line_d       = next_line_y;
            idx_d        = '0;
            shadow_d     = '0;
            shadow_cnt_d = '0;
            rd_pending_d = 1'b0;
        end

        late_set   = abort || (pixel_valid && scan_busy);
        overflow_d = (overflow_q && !frame_start) || overflow_set;
        late_d     = (late_q && !frame_start) || late_set;
    end

    always_comb begin
        for (int s = 0; s < SLOT_NUM; s++) begin
            slot_valid[s] = active_q[s].valid;
            slot_len[s]   = active_q[s].len;
            slot_scr_x[s] = active_q[s].scr_x;
        end
    end

    obstacle_slot_match u_slot_match (
        .pixel_x    (pixel_x),
        .slot_valid (slot_valid),
        .slot_len   (slot_len),
        .slot_scr_x (slot_scr_x),
        .hit        (match_hit),
        .slot_idx   (match_idx),
        .x_off      (match_x_off)
    );

    always_comb begin
        on_d          = 1'b0;
        x_rom_d       = '0;
        y_rom_d       = '0;
        abs_x_d       = '0;
        abs_y_d       = '0;
        block_abs_y_d = '0;
        if (pixel_valid && match_hit) begin
            on_d          = 1'b1;
            x_rom_d       = match_x_off;
            y_rom_d       = active_line_q - active_q[match_idx].scr_y;
            abs_x_d       = active_q[match_idx].abs_x;
            abs_y_d       = active_q[match_idx].abs_y;
            block_abs_y_d = active_q[match_idx].abs_y + PHY_WIDTH'(y_rom_d);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            line_q        <= '0;
            // NOTE: the slot arrays are small register files and must come up invalid, so they are reset like any other flop.
            shadow_q      <= '0;
            shadow_cnt_q  <= '0;
            active_q      <= '0;
            active_line_q <= '0;
            rd_pending_q  <= 1'b0;
            overflow_q    <= 1'b0;
            late_q        <= 1'b0;
            on_q          <= 1'b0;
            x_rom_q       <= '0;
            y_rom_q       <= '0;
            abs_x_q       <= '0;
            abs_y_q       <= '0;
            block_abs_y_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbours.
            state_q       <= state_d;
            idx_q         <= idx_d;
            line_q        <= line_d;
            shadow_q      <= shadow_d;
            shadow_cnt_q  <= shadow_cnt_d;
            active_q      <= active_d;
            active_line_q <= active_line_d;
            rd_pending_q  <= rd_pending_d;
            overflow_q    <= overflow_d;
            late_q        <= late_d;
            on_q          <= on_d;
            x_rom_q       <= x_rom_d;
            y_rom_q       <= y_rom_d;
            abs_x_q       <= abs_x_d;
            abs_y_q       <= abs_y_d;
            block_abs_y_q <= block_abs_y_d;
        end
    end

    assign obstacle_on          = on_q;
    assign obstacle_x_rom       = x_rom_q;
    assign obstacle_y_rom       = y_rom_q;
    assign obstacle_abs_pos_x   = abs_x_q;
    assign obstacle_abs_pos_y   = abs_y_q;
    assign obstacle_block_abs_y = block_abs_y_q;
    assign overflow             = overflow_q;
    assign late                 = late_q;

endmodule

// File: tb/tb_obstacle_line_scheduler.sv
// Randomised and directed bench for obstacle_line_scheduler against a
// table-walking reference model.
module tb_obstacle_line_scheduler;

    localparam int N = 16;

    logic        sys_clk;
    logic        sys_rst;
    logic        frame_start;
    logic        line_start;
    logic [9:0]  next_line_y;
    logic        pixel_valid;
    logic [9:0]  pixel_x;
    logic        tbl_rd_en;
    logic [3:0]  tbl_addr;
    logic [52:0] tbl_rd_data;
    logic        obstacle_on;
    logic [9:0]  obstacle_x_rom;
    logic [9:0]  obstacle_y_rom;
    logic [13:0] obstacle_abs_pos_x;
    logic [13:0] obstacle_abs_pos_y;
    logic [13:0] obstacle_block_abs_y;
    logic        scan_busy;
    logic        overflow;
    logic        late;

    int t_valid[N];
    int t_len[N];
    int t_sy[N];
    int t_sx[N];
    int t_ay[N];
    int t_ax[N];

    int n_cmp;
    int n_fail;

    logic [62:0] pix_got;
    logic [70:0] all_out;
    assign pix_got = {obstacle_on, obstacle_x_rom, obstacle_y_rom,
                      obstacle_abs_pos_x, obstacle_abs_pos_y, obstacle_block_abs_y};
    assign all_out = {pix_got, scan_busy, overflow, late, tbl_rd_en, tbl_addr};

    obstacle_line_scheduler dut (
        .sys_clk              (sys_clk),
        .sys_rst              (sys_rst),
        .frame_start          (frame_start),
        .line_start           (line_start),
        .next_line_y          (next_line_y),
        .pixel_valid          (pixel_valid),
        .pixel_x              (pixel_x),
        .tbl_rd_en            (tbl_rd_en),
        .tbl_addr             (tbl_addr),
        .tbl_rd_data          (tbl_rd_data),
        .obstacle_on          (obstacle_on),
        .obstacle_x_rom       (obstacle_x_rom),
        .obstacle_y_rom       (obstacle_y_rom),
        .obstacle_abs_pos_x   (obstacle_abs_pos_x),
        .obstacle_abs_pos_y   (obstacle_abs_pos_y),
        .obstacle_block_abs_y (obstacle_block_abs_y),
        .scan_busy            (scan_busy),
        .overflow             (overflow),
        .late                 (late)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Synchronous table memory: data appears the cycle after the read strobe.
    always @(posedge sys_clk) begin
        if (tbl_rd_en)
            tbl_rd_data <= {t_valid[tbl_addr] != 0, 4'(t_len[tbl_addr]), 10'(t_sy[tbl_addr]),
                            10'(t_sx[tbl_addr]), 14'(t_ay[tbl_addr]), 14'(t_ax[tbl_addr])};
    end

    // Reference: walk the table in order, keep the first four vertical hits,
    // and report the first kept entry whose horizontal span covers px.
    function automatic logic [62:0] model_pixel(input int line, input int px);
        logic [62:0] r;
        int hits;
        r = '0;
        hits = 0;
        for (int i = 0; i < N; i++) begin
            if (t_valid[i] != 0 && t_len[i] > 0 && line >= t_sy[i] && line < t_sy[i] + 20) begin
                if (hits < 4 && !r[62] && px >= t_sx[i] && px < t_sx[i] + t_len[i] * 10)
                    r = {1'b1, 10'(px - t_sx[i]), 10'(line - t_sy[i]), 14'(t_ax[i]),
                         14'(t_ay[i]), 14'(t_ay[i] + line - t_sy[i])};
                hits++;
            end
        end
        return r;
    endfunction

    function automatic logic model_overflow(input int line);
        int hits;
        hits = 0;
        for (int i = 0; i < N; i++)
            if (t_valid[i] != 0 && t_len[i] > 0 && line >= t_sy[i] && line < t_sy[i] + 20) hits++;
        return hits > 4;
    endfunction

    task automatic clear_table();
        for (int i = 0; i < N; i++) begin
            t_valid[i] = 0; t_len[i] = 0; t_sy[i] = 0; t_sx[i] = 0; t_ay[i] = 0; t_ax[i] = 0;
        end
    endtask

    task automatic set_entry(input int i, input int v, input int len, input int sy,
                             input int sx, input int ay, input int ax);
        t_valid[i] = v; t_len[i] = len; t_sy[i] = sy; t_sx[i] = sx; t_ay[i] = ay; t_ax[i] = ax;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        @(negedge sys_clk);
        frame_start = 1'b0;
    endtask

    task automatic probe(input int px);
        pixel_valid = 1'b1;
        pixel_x     = 10'(px);
        @(negedge sys_clk);
        pixel_valid = 1'b0;
    endtask

    // Full line scan; also checks the read-address walk and commit latency.
    task automatic run_line(input int y);
        bit ok;
        int bad_k;
        ok = 1'b1;
        bad_k = -1;
        line_start  = 1'b1;
        next_line_y = 10'(y);
        @(negedge sys_clk);
        line_start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (tbl_rd_en !== 1'b1 || tbl_addr !== 4'(k) || scan_busy !== 1'b1) begin
                ok = 1'b0;
                if (bad_k < 0) bad_k = k;
            end
            @(negedge sys_clk);
        end
        if (tbl_rd_en !== 1'b0 || scan_busy !== 1'b1) begin ok = 1'b0; bad_k = 16; end
        @(negedge sys_clk);
        if (tbl_rd_en !== 1'b0 || scan_busy !== 1'b1) begin ok = 1'b0; bad_k = 17; end
        @(negedge sys_clk);
        if (scan_busy !== 1'b0) begin ok = 1'b0; bad_k = 18; end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL scan_seq line=%0d first bad cycle=%0d got busy=%b rd_en=%b addr=%0d",
                     y, bad_k, scan_busy, tbl_rd_en, tbl_addr);
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        n_cmp++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h expected 0", all_out);
        end
        sys_rst = 1'b0;
        @(negedge sys_clk);
        probe(5);
        n_cmp++;
        if (pix_got !== '0) begin
            n_fail++;
            $display("FAIL reset_pixel got %h expected 0", pix_got);
        end
    endtask

    task automatic test_single();
        int pxs[5] = '{229, 230, 200, 199, 0};
        clear_table();
        set_entry(0, 1, 3, 100, 200, 500, 40);
        run_line(105);
        probe(229);
        n_cmp++;
        if ({obstacle_on, obstacle_x_rom, obstacle_y_rom, obstacle_abs_pos_x, obstacle_block_abs_y}
            !== {1'b1, 10'd29, 10'd5, 14'd40, 14'd505}) begin
            n_fail++;
            $display("FAIL single_229 got on=%b x=%0d y=%0d ax=%0d bay=%0d expected 1 29 5 40 505",
                     obstacle_on, obstacle_x_rom, obstacle_y_rom, obstacle_abs_pos_x, obstacle_block_abs_y);
        end
        foreach (pxs[i]) begin
            probe(pxs[i]);
            n_cmp++;
            if (pix_got !== model_pixel(105, pxs[i])) begin
                n_fail++;
                $display("FAIL single_px%0d got %h expected %h", pxs[i], pix_got, model_pixel(105, pxs[i]));
            end
        end
    endtask

    task automatic test_vertical_edges();
        int lines[2] = '{99, 120};
        int seen;
        foreach (lines[j]) begin
            run_line(lines[j]);
            seen = -1;
            for (int px = 0; px < 1024; px++) begin
                probe(px);
                if (obstacle_on !== 1'b0 && seen < 0) seen = px;
            end
            n_cmp++;
            if (seen >= 0) begin
                n_fail++;
                $display("FAIL vedge_line%0d got on=1 at px=%0d expected on=0 everywhere", lines[j], seen);
            end
        end
        run_line(119);
        probe(210);
        n_cmp++;
        if (obstacle_on !== 1'b1 || obstacle_y_rom !== 10'd19) begin
            n_fail++;
            $display("FAIL vedge_119 got on=%b y_rom=%0d expected 1 19", obstacle_on, obstacle_y_rom);
        end
        run_line(100);
        probe(215);
        n_cmp++;
        if (pix_got !== model_pixel(100, 215) || obstacle_y_rom !== 10'd0) begin
            n_fail++;
            $display("FAIL vedge_100 got %h expected %h", pix_got, model_pixel(100, 215));
        end
    endtask

    task automatic test_overflow();
        int pxs[6] = '{105, 205, 305, 310, 405, 505};
        pulse_frame();
        clear_table();
        for (int i = 0; i < 6; i++) set_entry(i, 1, 2, 40, 100 * i, 3000 + i, 1000 + i);
        run_line(50);
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set got %b expected 1", overflow);
        end
        foreach (pxs[i]) begin
            probe(pxs[i]);
            n_cmp++;
            if (pix_got !== model_pixel(50, pxs[i])) begin
                n_fail++;
                $display("FAIL overflow_px%0d got %h expected %h", pxs[i], pix_got, model_pixel(50, pxs[i]));
            end
        end
        probe(410);
        n_cmp++;
        if (obstacle_on !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_dropped got on=%b expected 0", obstacle_on);
        end
        pulse_frame();
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_clear got %b expected 0", overflow);
        end
    endtask

    task automatic test_priority();
        int pxs[5] = '{12, 16, 24, 27, 31};
        clear_table();
        set_entry(2, 1, 2, 60, 10, 700, 111);
        set_entry(5, 1, 1, 55, 15, 800, 222);
        run_line(65);
        probe(18);
        n_cmp++;
        if (obstacle_on !== 1'b1 || obstacle_abs_pos_x !== 14'd111 || obstacle_x_rom !== 10'd8) begin
            n_fail++;
            $display("FAIL priority_18 got on=%b ax=%0d x_rom=%0d expected 1 111 8",
                     obstacle_on, obstacle_abs_pos_x, obstacle_x_rom);
        end
        foreach (pxs[i]) begin
            probe(pxs[i]);
            n_cmp++;
            if (pix_got !== model_pixel(65, pxs[i])) begin
                n_fail++;
                $display("FAIL priority_px%0d got %h expected %h", pxs[i], pix_got, model_pixel(65, pxs[i]));
            end
        end
    endtask

    task automatic test_abort();
        bit ok;
        logic [62:0] got;
        got = '0;
        clear_table();
        set_entry(0, 1, 1, 11, 100, 900, 1);
        set_entry(1, 1, 1, 31, 300, 950, 2);
        run_line(30);
        pulse_frame();
        n_cmp++;
        if (late !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_pre_late got %b expected 0", late);
        end
        line_start  = 1'b1;
        next_line_y = 10'd30;
        @(negedge sys_clk);
        line_start = 1'b0;
        repeat (4) @(negedge sys_clk);
        line_start  = 1'b1;
        next_line_y = 10'd31;
        frame_start = 1'b1;
        @(negedge sys_clk);
        line_start  = 1'b0;
        frame_start = 1'b0;
        n_cmp++;
        if (late !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_late got %b expected 1", late);
        end
        ok = 1'b1;
        for (int k = 0; k < 18; k++) begin
            if (scan_busy !== 1'b1) ok = 1'b0;
            if (k == 2) begin pixel_valid = 1'b1; pixel_x = 10'd105; end
            if (k == 3) begin pixel_valid = 1'b0; got = pix_got; end
            @(negedge sys_clk);
        end
        if (scan_busy !== 1'b0) ok = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL abort_latency got busy profile wrong, busy now=%b expected 0 after 18 cycles", scan_busy);
        end
        n_cmp++;
        if (got !== model_pixel(30, 105)) begin
            n_fail++;
            $display("FAIL abort_old_list got %h expected %h", got, model_pixel(30, 105));
        end
        probe(305);
        n_cmp++;
        if (pix_got !== model_pixel(31, 305) || obstacle_on !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_new_305 got %h expected %h", pix_got, model_pixel(31, 305));
        end
        probe(105);
        n_cmp++;
        if (obstacle_on !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_new_105 got on=%b expected 0", obstacle_on);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_table();
        set_entry(1, 1, 2, 290, 40, 100, 11);
        set_entry(3, 1, 3, 300, 70, 200, 22);
        set_entry(9, 1, 1, 305, 50, 300, 33);
        pulse_frame();
        ok = 1'b1;
        line_start  = 1'b1;
        next_line_y = 10'd300;
        @(negedge sys_clk);
        line_start = 1'b0;
        repeat (17) @(negedge sys_clk);
        if (scan_busy !== 1'b1) ok = 1'b0;
        line_start  = 1'b1;
        next_line_y = 10'd310;
        @(negedge sys_clk);
        line_start = 1'b0;
        for (int k = 0; k < 18; k++) begin
            if (scan_busy !== 1'b1) ok = 1'b0;
            @(negedge sys_clk);
        end
        if (scan_busy !== 1'b0) ok = 1'b0;
        n_cmp++;
        if (!ok || late !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_timing got busy=%b late=%b expected 0 0 after commit-cycle restart", scan_busy, late);
        end
        for (int px = 40; px < 100; px += 7) begin
            probe(px);
            n_cmp++;
            if (pix_got !== model_pixel(310, px)) begin
                n_fail++;
                $display("FAIL b2b_px%0d got %h expected %h", px, pix_got, model_pixel(310, px));
            end
        end
    endtask

    task automatic test_random();
        int line, d, sel, px;
        for (int it = 0; it < 25; it++) begin
            line = int'($urandom_range(0, 1023));
            for (int i = 0; i < N; i++) begin
                d = int'($urandom_range(0, 24));
                set_entry(i, ($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : ((line - d < 0) ? 0 : line - d),
                          int'($urandom_range(0, 1023)), int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383)));
            end
            pulse_frame();
            run_line(line);
            n_cmp++;
            if (overflow !== model_overflow(line)) begin
                n_fail++;
                $display("FAIL rand%0d_overflow got %b expected %b", it, overflow, model_overflow(line));
            end
            for (int p = 0; p < 8; p++) begin
                sel = int'($urandom_range(0, N - 1));
                d   = int'($urandom_range(0, 160));
                px  = (t_sx[sel] + d - 2) & 1023;
                probe(px);
                n_cmp++;
                if (pix_got !== model_pixel(line, px)) begin
                    n_fail++;
                    $display("FAIL rand%0d_px%0d got %h expected %h", it, px, pix_got, model_pixel(line, px));
                end
            end
        end
        n_cmp++;
        if (late !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_late got %b expected 0", late);
        end
    endtask

    task automatic test_wrap_reset();
        int pxs[3] = '{1023, 2, 1019};
        clear_table();
        set_entry(0, 1, 1, 200, 1020, 60, 77);
        run_line(205);
        probe(1023);
        n_cmp++;
        if (obstacle_on !== 1'b1 || obstacle_x_rom !== 10'd3) begin
            n_fail++;
            $display("FAIL wrap_1023 got on=%b x_rom=%0d expected 1 3", obstacle_on, obstacle_x_rom);
        end
        foreach (pxs[i]) begin
            probe(pxs[i]);
            n_cmp++;
            if (pix_got !== model_pixel(205, pxs[i])) begin
                n_fail++;
                $display("FAIL wrap_px%0d got %h expected %h", pxs[i], pix_got, model_pixel(205, pxs[i]));
            end
        end
        line_start  = 1'b1;
        next_line_y = 10'd205;
        @(negedge sys_clk);
        line_start = 1'b0;
        repeat (6) @(negedge sys_clk);
        pixel_valid = 1'b1;
        pixel_x     = 10'd1023;
        sys_rst     = 1'b1;
        @(negedge sys_clk);
        n_cmp++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL midscan_reset got %h expected 0", all_out);
        end
        sys_rst     = 1'b0;
        pixel_valid = 1'b0;
        repeat (25) @(negedge sys_clk);
        probe(1023);
        n_cmp++;
        if (obstacle_on !== 1'b0 || scan_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_commit got on=%b busy=%b expected 0 0", obstacle_on, scan_busy);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        sys_rst     = 1'b1;
        frame_start = 1'b0;
        line_start  = 1'b0;
        next_line_y = '0;
        pixel_valid = 1'b0;
        pixel_x     = '0;
        tbl_rd_data = '0;
        clear_table();
        @(negedge sys_clk);

        test_reset();
        test_single();
        test_vertical_edges();
        test_overflow();
        test_priority();
        test_abort();
        test_back_to_back();
        test_random();
        test_wrap_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
